// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file sequencer slice.
//   - default widths for data, register address and instruction word
//   - instruction field positions (opcode/dest/src1/src2-or-imm)
//   - opcode constants
//   - sequencer FSM state encoding
package regfile_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned ADDR_W_DEF  = 3;
  localparam int unsigned INSTR_W_DEF = 32;

  // Every instruction field is one byte wide.
  localparam int unsigned FIELD_W  = 8;
  localparam int unsigned OPC_LSB  = 24;
  localparam int unsigned DEST_LSB = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;

  localparam logic [FIELD_W-1:0] OP_LOADI = 8'h00;
  localparam logic [FIELD_W-1:0] OP_MOV   = 8'h01;
  localparam logic [FIELD_W-1:0] OP_ADD   = 8'h02;
  localparam logic [FIELD_W-1:0] OP_SUB   = 8'h03;
  localparam logic [FIELD_W-1:0] OP_AND   = 8'h04;
  localparam logic [FIELD_W-1:0] OP_OR    = 8'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the register-file sequencer.
// Ports:
//   i_opcode  - instruction opcode byte
//   i_a, i_b  - operands read from the register file (OUT1, OUT2)
//   i_imm     - immediate operand (used by LOADI)
//   o_result  - result, modulo 2^DATA_W
//   o_illegal - opcode is not one of LOADI/MOV/ADD/SUB/AND/OR
module seq_alu
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [FIELD_W-1:0] i_opcode,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic [DATA_W-1:0]  i_imm,
  output logic [DATA_W-1:0]  o_result,
  output logic               o_illegal
);

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_LOADI: o_result = i_imm;
      OP_MOV:   o_result = i_b;
      OP_ADD:   o_result = i_a + i_b;
      OP_SUB:   o_result = i_a - i_b;
      OP_AND:   o_result = i_a & i_b;
      OP_OR:    o_result = i_a | i_b;
      default:  o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction-side driver of the 8x8 register file.
// One instruction per valid/ready transaction walks IDLE -> READ -> EXEC -> WB.
// Ports:
//   clk, RESET          - clock, synchronous active-high reset
//   instr, instr_valid  - decoded instruction and its valid strobe
//   instr_ready         - high only in IDLE
//   OUT1addr, OUT2addr  - register-file read addresses (src1, src2)
//   OUT1, OUT2          - register-file read data (combinational from addresses)
//   INaddr, IN, WRITE   - register-file write port, WRITE high for one cycle (WB)
//   done, err           - completion pulse; err flags an illegal opcode
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [ADDR_W-1:0]  OUT1addr,
  output logic [ADDR_W-1:0]  OUT2addr,
  input  logic [DATA_W-1:0]  OUT1,
  input  logic [DATA_W-1:0]  OUT2,
  output logic [ADDR_W-1:0]  INaddr,
  output logic [DATA_W-1:0]  IN,
  output logic               WRITE,
  output logic               done,
  output logic               err
);

  seq_state_e          r_state,     w_state_nxt;
  logic [FIELD_W-1:0]  r_opcode,    w_opcode_nxt;
  logic [ADDR_W-1:0]   r_dest,      w_dest_nxt;
  logic [ADDR_W-1:0]   r_src1,      w_src1_nxt;
  logic [FIELD_W-1:0]  r_fld2,      w_fld2_nxt;     // src2 address or immediate
  logic [ADDR_W-1:0]   r_out1addr,  w_out1addr_nxt;
  logic [ADDR_W-1:0]   r_out2addr,  w_out2addr_nxt;
  logic [ADDR_W-1:0]   r_inaddr,    w_inaddr_nxt;
  logic [DATA_W-1:0]   r_in,        w_in_nxt;       // result register
  logic                r_write,     w_write_nxt;
  logic                r_done,      w_done_nxt;
  logic                r_err,       w_err_nxt;
  logic                r_ready,     w_ready_nxt;

  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_alu_result;
  logic                w_alu_illegal;

  // High bits of the register fields are don't-care.
  logic w_unused_instr;
  assign w_unused_instr = ^{instr[DEST_LSB+FIELD_W-1:DEST_LSB+ADDR_W],
                            instr[SRC1_LSB+FIELD_W-1:SRC1_LSB+ADDR_W]};

  assign w_imm = DATA_W'(r_fld2);

  seq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_opcode  (r_opcode),
    .i_a       (OUT1),
    .i_b       (OUT2),
    .i_imm     (w_imm),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_opcode_nxt   = r_opcode;
    w_dest_nxt     = r_dest;
    w_src1_nxt     = r_src1;
    w_fld2_nxt     = r_fld2;
    w_out1addr_nxt = r_out1addr;
    w_out2addr_nxt = r_out2addr;
    w_inaddr_nxt   = r_inaddr;
    w_in_nxt       = r_in;
    w_write_nxt    = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (instr_valid && r_ready) begin
          w_opcode_nxt = instr[OPC_LSB +: FIELD_W];
          w_dest_nxt   = instr[DEST_LSB +: ADDR_W];
          w_src1_nxt   = instr[SRC1_LSB +: ADDR_W];
          w_fld2_nxt   = instr[SRC2_LSB +: FIELD_W];
          w_state_nxt  = ST_READ;
        end
      end
      ST_READ: begin
        w_out1addr_nxt = r_src1;
        w_out2addr_nxt = r_fld2[ADDR_W-1:0];
        w_state_nxt    = ST_EXEC;
      end
      ST_EXEC: begin
        // Write-port outputs are registered here so they are valid for
        // the whole WB cycle.
        w_inaddr_nxt = r_dest;
        if (!w_alu_illegal) begin
          w_in_nxt = w_alu_result;
        end
        w_write_nxt = !w_alu_illegal;
        w_err_nxt   = w_alu_illegal;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_WB;
      end
      ST_WB: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_opcode   <= '0;
      r_dest     <= '0;
      r_src1     <= '0;
      r_fld2     <= '0;
      r_out1addr <= '0;
      r_out2addr <= '0;
      r_inaddr   <= '0;
      r_in       <= '0;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_opcode   <= w_opcode_nxt;
      r_dest     <= w_dest_nxt;
      r_src1     <= w_src1_nxt;
      r_fld2     <= w_fld2_nxt;
      r_out1addr <= w_out1addr_nxt;
      r_out2addr <= w_out2addr_nxt;
      r_inaddr   <= w_inaddr_nxt;
      r_in       <= w_in_nxt;
      r_write    <= w_write_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign instr_ready = r_ready;
  assign OUT1addr    = r_out1addr;
  assign OUT2addr    = r_out2addr;
  assign INaddr      = r_inaddr;
  assign IN          = r_in;
  assign WRITE       = r_write;
  assign done        = r_done;
  assign err         = r_err;

endmodule
